// File: rtl/brew_sensor_pkg.sv
// Shared definitions for the brewery sensor front end.
// Holds the ADC sequencer state encoding, the frame geometry and the
// open-sensor pattern. The top level and the averager import it.
package brew_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_PROCESS
  } state_e;

  localparam int          FRAME_BITS    = 16;
  localparam logic [15:0] FAULT_PATTERN = 16'hFFFF;
  localparam int          LEVEL_MSB     = 15;
  localparam int          TEMP_MSB      = 7;
  localparam int          CH_W          = 8;

endpackage

// File: rtl/brew_boxcar_avg.sv
// Boxcar averager for one 8-bit sensor channel.
// It collects 2^AVG_LOG2 samples, then presents their truncated mean and
// pulses done_o for one cycle. After that it starts a fresh window.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   add_i       accumulate sample_i this cycle
//   sample_i    8-bit sample
//   done_o      one-cycle strobe: mean_o was just updated
//   mean_o      mean of the last full window, held between strobes
module brew_boxcar_avg
  import brew_sensor_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            add_i,
  input  logic [CH_W-1:0] sample_i,
  output logic            done_o,
  output logic [CH_W-1:0] mean_o
);

  // The accumulator is exactly wide enough for 2^AVG_LOG2 * 255.
  localparam int ACC_W = CH_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  mean_q, mean_d;
  logic             done_q, done_d;

  always_comb begin
    sum    = acc_q + ACC_W'(sample_i);
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mean_d = mean_q;
    done_d = 1'b0;
    if (add_i) begin
      if (cnt_q == LAST) begin
        mean_d = sum[ACC_W-1:AVG_LOG2];
        done_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mean_q <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mean_q <= mean_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign mean_o = mean_q;

endmodule

// File: rtl/brew_sensor_frontend.sv
// Brewery sensor front end. It polls a 2-channel serial ADC every
// SAMPLE_PERIOD cycles and drops open-sensor frames (all ones). It then
// boxcar-averages the good frames for each channel.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   adc_miso      ADC serial data, MSB first
//   adc_cs_n      ADC chip select, active low (registered)
//   adc_sclk      ADC serial clock, idles low (registered)
//   valid         one-cycle strobe: level_sensor/temperature updated
//   level_sensor  averaged tank level (frame bits 15:8)
//   temperature   averaged mash temperature (frame bits 7:0)
//   sensor_fault  last completed frame was the open-sensor pattern
module brew_sensor_frontend
  import brew_sensor_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       valid,
  output logic [7:0] level_sensor,
  output logic [7:0] temperature,
  output logic       sensor_fault
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Free-running sample period counter
  logic [PW-1:0] per_q, per_d;
  logic          tick;

  assign tick  = (per_q == PW'(SAMPLE_PERIOD - 1));
  assign per_d = tick ? '0 : per_q + 1'b1;

  // Sequencer
  state_e                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic                  hi_q, hi_d;     // sclk phase within the current bit
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic                  fault_q, fault_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  add;
  logic                  div_last;

  assign div_last = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hi_d    = hi_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    fault_d = fault_q;
    add     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (tick) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d = '0;
          if (!hi_q) begin
            // sclk rises on this edge. Capture the bit the ADC is presenting.
            hi_d = 1'b1;
            sh_d = {sh_q[FRAME_BITS-2:0], adc_miso};
          end else begin
            hi_d = 1'b0;
            if (bit_q == 4'(FRAME_BITS - 1)) state_d = ST_HOLD;
            else                             bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          state_d = ST_PROCESS;
          div_d   = '0;
        end
      end
      ST_PROCESS: begin
        state_d = ST_IDLE;
        if (sh_q == FAULT_PATTERN) begin
          fault_d = 1'b1;
        end else begin
          fault_d = 1'b0;
          add     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The pins are registered from the next state, so they line up with the state register.
    cs_n_d = !(state_d == ST_SETUP || state_d == ST_SHIFT || state_d == ST_HOLD);
    sclk_d = (state_d == ST_SHIFT) && hi_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_q   <= '0;
      state_q <= ST_IDLE;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      fault_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      per_q   <= per_d;
      state_q <= state_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      fault_q <= fault_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

  logic lvl_done, tmp_done;

  brew_boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_level (
    .clk      (clk),
    .reset    (reset),
    .add_i    (add),
    .sample_i (sh_q[LEVEL_MSB -: CH_W]),
    .done_o   (lvl_done),
    .mean_o   (level_sensor)
  );

  brew_boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_temp (
    .clk      (clk),
    .reset    (reset),
    .add_i    (add),
    .sample_i (sh_q[TEMP_MSB -: CH_W]),
    .done_o   (tmp_done),
    .mean_o   (temperature)
  );

  // Both averagers share the add strobe, so the two done flags are always equal.
  assign valid        = lvl_done & tmp_done;
  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sensor_fault = fault_q;

endmodule

// File: doc/brew_sensor_frontend.md
Name: brew_sensor_frontend

Overview:
Upstream sensor stage for the brewery controller. Periodically reads a 2-channel serial ADC (tank level, mash temperature), rejects disconnected-sensor frames, and boxcar-averages 2^AVG_LOG2 good frames per channel. It presents the averaged pair with a one-cycle valid strobe, which the brew system latches into its level register and feeds to the brew FSM.

Parameters:
CLK_DIV, 4, clk cycles per adc_sclk half-period (>=1)
SAMPLE_PERIOD, 1000, clk cycles between frame starts (>= 34*CLK_DIV+2)
AVG_LOG2, 2, log2 of the number of good frames averaged per output (0..4; 0 = every good frame is output)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
adc_miso  input  1  ADC serial data, MSB first
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock, idles low
valid  output  1  one-cycle strobe: level_sensor/temperature updated
level_sensor  output  8  averaged tank level
temperature  output  8  averaged mash temperature
sensor_fault  output  1  last frame was 16'hFFFF (open sensor)

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs registered.
- Reset values: adc_cs_n=1, adc_sclk=0, valid=0, level_sensor=0, temperature=0, sensor_fault=0. Period counter=0, accumulators and frame count=0, FSM=IDLE.
- Period counter: free-running 0..SAMPLE_PERIOD-1, wraps. tick=1 when count==SAMPLE_PERIOD-1. First tick is in cycle SAMPLE_PERIOD-1 after reset release. The parameter constraint guarantees FSM is IDLE at every tick.
- FSM states:
  IDLE: cs_n=1, sclk=0. On tick -> SETUP.
  SETUP: cs_n=0 for CLK_DIV cycles -> SHIFT.
  SHIFT: 16 bits. Each bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles. adc_miso is shifted into a 16-bit register in the cycle adc_sclk goes 0->1. After the 16th high phase, sclk=0 -> HOLD.
  HOLD: cs_n=0, sclk=0 for CLK_DIV cycles -> PROCESS.
  PROCESS: single cycle, cs_n=1 -> IDLE.
- Frame format: bits[15:8]=level, bits[7:0]=temperature.
- cs_n low duration per frame is exactly 34*CLK_DIV cycles.
- PROCESS, fault frame (frame==16'hFFFF):
  - sensor_fault<=1.
  - Accumulators and frame count untouched; no valid.
- PROCESS, good frame:
  - sensor_fault<=0.
  - Add each channel into its (8+AVG_LOG2)-bit accumulator; frame count+1.
  - When frame count reaches 2^AVG_LOG2: level_sensor/temperature <= sum>>AVG_LOG2 (truncate, never overflows), valid<=1 in the next cycle only. Accumulators and count cleared for the next window.
- Latency: valid is high in the cycle immediately after PROCESS of the completing frame.
- valid is a strobe. Data outputs hold their value between strobes. There is no back-pressure; the consumer must sample on valid.
- Reset mid-frame: next cycle cs_n=1, sclk=0, partial frame and accumulators discarded, no valid. The period counter restarts from 0.
- Bit order and sampling are fixed; there is no frame-level timeout (the ADC always returns 16 bits).

Decomposition:
- Shared package brew_sensor_pkg:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, PROCESS)
  - FRAME_BITS=16
  - FAULT_PATTERN=16'hFFFF
  - LEVEL_MSB=15, TEMP_MSB=7 field positions
- Natural sub-module: brew_boxcar_avg, instantiated twice, one per channel.
  - Inputs: clk, reset, add strobe, 8-bit sample.
  - Outputs: done strobe, 8-bit mean.
  - Parameter: AVG_LOG2.
  - Both instances share the add strobe, so their done strobes are simultaneous. valid is taken from the level instance.

Test Plan:
(CLK_DIV=2, SAMPLE_PERIOD=100, AVG_LOG2=2 unless stated)
- Reset for 3 cycles, release -> all outputs at reset values; adc_cs_n first falls at cycle 100 after release (SETUP entered after tick at cycle 99).
- One frame -> cs_n low exactly 68 cycles, 16 sclk rising edges spaced 4 cycles, first rising edge 4 cycles after cs_n falls; shifted value matches driven 16'h3A7C.
- Four frames level 0x10,0x20,0x30,0x41, temp 0x50 each -> exactly one valid pulse after the 4th PROCESS with level_sensor=0x28, temperature=0x50; no valid after frames 1-3.
- Five frames, 2nd = 16'hFFFF, others level 0x40 / temp 0x64 -> sensor_fault=1 after frame 2, back to 0 after frame 3; valid only after frame 5 with 0x40/0x64.
- Reset asserted in the 8th SHIFT bit -> cs_n=1 and sclk=0 the next cycle; no valid; the following window needs 4 fresh good frames.
- Four frames level 0xFF / temp 0xFE -> outputs 0xFF/0xFE (no accumulator overflow). With AVG_LOG2=0, every good frame produces valid with raw values.
